// File: rtl/rom_share_arbiter_pkg.sv
// rom_share_arbiter_pkg: FSM state encodings and owner constants shared by the ROM arbiter
package rom_share_arbiter_pkg;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;
  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;
endpackage

// File: rtl/rom_share_arbiter_if.sv
// rom_share_arbiter_if: two requester ports (req/addr/gnt/rvalid/rdata), ROM side (rom_addr/rom_q) and busy
interface rom_share_arbiter_if #(parameter int ADDR_W = 5, parameter int DATA_W = 4);
  logic              req0, req1, gnt0, gnt1, rvalid0, rvalid1, busy;
  logic [ADDR_W-1:0] addr0, addr1, rom_addr;
  logic [DATA_W-1:0] rdata0, rdata1, rom_q;
  modport master (
    output req0, addr0, req1, addr1, rom_q,
    input  gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1, rom_addr, busy
  );
  modport slave (
    input  req0, addr0, req1, addr1, rom_q,
    output gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1, rom_addr, busy
  );
endinterface

// File: rtl/rom_share_arbiter_rr_pick2.sv
// rr_pick2: two-way round-robin picker; clk/rst/req0/req1/upd in, any/win out, last grant reg resets to port 1
module rr_pick2
  import rom_share_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic upd,
  output logic any,
  output logic win
);
  logic last;
  assign any = req0 | req1;
  assign win = (req0 & req1) ? ~last : (req1 ? PORT1 : PORT0);
  always_ff @(posedge clk)
    if (rst) last <= PORT1;
    else if (upd) last <= win;
endmodule

// File: rtl/rom_share_arbiter.sv
// rom_share_arbiter: one-at-a-time ROM reads for two ports; clk, rst, bus (slave: req/addr in, gnt/rvalid/rdata/rom_addr/busy out, rom_q in)
module rom_share_arbiter
  import rom_share_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 4,
  parameter int ROM_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  rom_share_arbiter_if.slave  bus
);
  logic [1:0]        state, lat_cnt;
  logic              owner, any, win, upd;
  logic              gnt0, gnt1, rv0, rv1;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rd0, rd1;
  assign upd = (state == S_IDLE) & any;
  rr_pick2 u_rr (
    .clk  (clk),
    .rst  (rst),
    .req0 (bus.req0),
    .req1 (bus.req1),
    .upd  (upd),
    .any  (any),
    .win  (win)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state    <= S_IDLE;
      lat_cnt  <= '0;
      owner    <= PORT0;
      rom_addr <= '0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      rv0      <= 1'b0;
      rv1      <= 1'b0;
      rd0      <= '0;
      rd1      <= '0;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      rv0  <= 1'b0;
      rv1  <= 1'b0;
      case (state)
        S_IDLE: if (any) begin
          rom_addr <= win ? bus.addr1 : bus.addr0;
          gnt0     <= win == PORT0;
          gnt1     <= win == PORT1;
          owner    <= win;
          state    <= S_ISSUE;
        end
        S_ISSUE: begin
          lat_cnt <= 2'(ROM_LAT - 1);
          state   <= (ROM_LAT == 1) ? S_RESP : S_WAIT;
        end
        S_WAIT: begin
          lat_cnt <= lat_cnt - 2'd1;
          state   <= (lat_cnt == 2'd1) ? S_RESP : S_WAIT;
        end
        default: begin
          rd0   <= (owner == PORT0) ? bus.rom_q : rd0;
          rd1   <= (owner == PORT1) ? bus.rom_q : rd1;
          rv0   <= owner == PORT0;
          rv1   <= owner == PORT1;
          state <= S_IDLE;
        end
      endcase
    end
  assign bus.gnt0     = gnt0;
  assign bus.gnt1     = gnt1;
  assign bus.rvalid0  = rv0;
  assign bus.rvalid1  = rv1;
  assign bus.rdata0   = rd0;
  assign bus.rdata1   = rd1;
  assign bus.rom_addr = rom_addr;
  assign bus.busy     = state != S_IDLE;
endmodule
